// File: rtl/pvr_interp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pvr_interp_pkg
// Description : Shared definitions for the plane interpolation walker:
//               default fixed-point format, walker FSM states and the
//               colour/alpha clamp ceiling.
// Revision    : 1.0 - initial release
// ============================================================================
package pvr_interp_pkg;

    // Fractional bits of plane coefficients and interpolated outputs.
    localparam int c_FRAC_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL_X = 2'd1,
        MUL_Y = 2'd2,
        WALK  = 2'd3
    } walker_state_t;

    // Largest clamped output: 255 + (2^FRAC_BITS - 1)/2^FRAC_BITS.
    localparam logic [31:0] c_CLAMP_MAX = 32'((64'd1 << (c_FRAC_BITS + 8)) - 64'd1);

    // Clamp ceiling for an arbitrary fractional width.
    function automatic logic [31:0] clamp_max(input int frac_bits);
        return 32'((64'd1 << (frac_bits + 8)) - 64'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/plane_span_walker_if.sv
`default_nettype none
// ============================================================================
// Module      : plane_span_walker_if
// Description : Command and pixel-output handshake bundle of the plane span
//               walker. The slave side is the walker, the master side is
//               plane setup (commands) together with the pixel consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface plane_span_walker_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_ddx;
    logic [31:0] cmd_ddy;
    logic [31:0] cmd_c;
    logic [15:0] cmd_x0;
    logic [15:0] cmd_y0;

    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_x;
    logic [15:0] out_y;
    logic [31:0] out_val;
    logic        out_last;

    logic        busy;

    modport master (
        output cmd_valid, cmd_ddx, cmd_ddy, cmd_c, cmd_x0, cmd_y0, out_ready,
        input  cmd_ready, out_valid, out_x, out_y, out_val, out_last, busy
    );

    modport slave (
        input  cmd_valid, cmd_ddx, cmd_ddy, cmd_c, cmd_x0, cmd_y0, out_ready,
        output cmd_ready, out_valid, out_x, out_y, out_val, out_last, busy
    );

endinterface
`default_nettype wire

// File: rtl/plane_mul_shift.sv
`default_nettype none
// ============================================================================
// Module      : plane_mul_shift
// Description : Combinational unsigned 16-bit origin times signed fixed-point
//               coefficient. The origin is promoted to fixed point, multiplied
//               and shifted back, keeping the low 32 bits (p*d mod 2^32).
//               FRAC_BITS must be at least 1.
// Revision    : 1.0 - initial release
// ============================================================================
module plane_mul_shift #(
    parameter int FRAC_BITS = 8
) (
    input  wire         [15:0] i_p,
    input  wire  signed [31:0] i_d,
    output logic signed [31:0] o_prod
);

    // Only the low 32+FRAC_BITS product bits can reach the truncated result.
    localparam int c_PW = 32 + FRAC_BITS;

    logic signed [c_PW-1:0] w_p_shift;
    logic signed [c_PW-1:0] w_d_ext;

    assign w_p_shift = signed'(c_PW'({i_p, {FRAC_BITS{1'b0}}}));
    assign w_d_ext   = c_PW'(i_d);
    assign o_prod    = 32'((w_p_shift * w_d_ext) >>> FRAC_BITS);

endmodule
`default_nettype wire

// File: rtl/plane_span_walker.sv
`default_nettype none
// ============================================================================
// Module      : plane_span_walker
// Description : Walks a TILE_W x TILE_H tile in raster order evaluating the
//               plane value*x*ddx + y*ddy + c by forward differencing, one
//               pixel per cycle. Build option INTERP_CLAMP_EN saturates the
//               output to [0, 255.996] for colour/alpha use; without it the
//               output is the raw wrapped accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module plane_span_walker
    import pvr_interp_pkg::*;
#(
    parameter int FRAC_BITS = c_FRAC_BITS,
    parameter int TILE_W    = 32,
    parameter int TILE_H    = 32
) (
    input wire                 clock,
    input wire                 reset_n,
    plane_span_walker_if.slave bus
);

    localparam int c_CW = (TILE_W > 1) ? $clog2(TILE_W) : 1;
    localparam int c_RW = (TILE_H > 1) ? $clog2(TILE_H) : 1;
    localparam logic [c_CW-1:0] c_COL_LAST = c_CW'(TILE_W - 1);
    localparam logic [c_RW-1:0] c_ROW_LAST = c_RW'(TILE_H - 1);

    walker_state_t r_state;
    walker_state_t w_state_nxt;

    logic [31:0]        r_ddx;
    logic [31:0]        r_ddy;
    logic [31:0]        r_c;
    logic [15:0]        r_x0;
    logic [15:0]        r_y0;
    logic [31:0]        r_acc;
    logic [31:0]        r_row_val;
    logic [31:0]        r_cur_val;
    logic [c_CW-1:0]    r_col;
    logic [c_RW-1:0]    r_row;

    logic               w_cmd_ready;
    logic               w_out_valid;
    logic               w_busy;
    logic               w_accept;
    logic               w_fire;
    logic               w_col_end;
    logic               w_row_end;
    logic [15:0]        w_mul_p;
    logic signed [31:0] w_mul_d;
    logic signed [31:0] w_mul_res;
    logic [31:0]        w_out_val;

    assign w_accept  = w_cmd_ready & bus.cmd_valid;
    assign w_fire    = w_out_valid & bus.out_ready;
    assign w_col_end = (r_col == c_COL_LAST);
    assign w_row_end = (r_row == c_ROW_LAST);

    // One multiplier serves both origin terms: x in MUL_X, y in MUL_Y.
    assign w_mul_p = (r_state == MUL_Y) ? r_y0 : r_x0;
    assign w_mul_d = (r_state == MUL_Y) ? signed'(r_ddy) : signed'(r_ddx);

    plane_mul_shift #(
        .FRAC_BITS (FRAC_BITS)
    ) u_mul (
        .i_p    (w_mul_p),
        .i_d    (w_mul_d),
        .o_prod (w_mul_res)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cmd_ready = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            IDLE: begin
                w_cmd_ready = 1'b1;
                w_busy      = 1'b0;
                if (bus.cmd_valid) begin
                    w_state_nxt = MUL_X;
                end
            end
            MUL_X: w_state_nxt = MUL_Y;
            MUL_Y: w_state_nxt = WALK;
            WALK: begin
                w_out_valid = 1'b1;
                if (bus.out_ready && w_col_end && w_row_end) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Command capture, plane origin evaluation and forward-difference walk.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_ddx     <= '0;
            r_ddy     <= '0;
            r_c       <= '0;
            r_x0      <= '0;
            r_y0      <= '0;
            r_acc     <= '0;
            r_row_val <= '0;
            r_cur_val <= '0;
            r_col     <= '0;
            r_row     <= '0;
        end else begin
            if (w_accept) begin
                r_ddx <= bus.cmd_ddx;
                r_ddy <= bus.cmd_ddy;
                r_c   <= bus.cmd_c;
                r_x0  <= bus.cmd_x0;
                r_y0  <= bus.cmd_y0;
            end
            if (r_state == MUL_X) begin
                r_acc <= r_c + w_mul_res;
            end
            if (r_state == MUL_Y) begin
                r_row_val <= r_acc + w_mul_res;
                r_cur_val <= r_acc + w_mul_res;
                r_col     <= '0;
                r_row     <= '0;
            end
            // Row start value is kept so each new row steps by ddy from it.
            if (w_fire) begin
                if (!w_col_end) begin
                    r_col     <= r_col + 1'b1;
                    r_cur_val <= r_cur_val + r_ddx;
                end else if (!w_row_end) begin
                    r_col     <= '0;
                    r_row     <= r_row + 1'b1;
                    r_row_val <= r_row_val + r_ddy;
                    r_cur_val <= r_row_val + r_ddy;
                end
            end
        end
    end

`ifdef INTERP_CLAMP_EN
    localparam logic [31:0] c_CLAMP_HI = clamp_max(FRAC_BITS);

    // Saturate the presented value only; the accumulators keep wrapping.
    always_comb begin
        w_out_val = r_cur_val;
        if (r_cur_val[31]) begin
            w_out_val = '0;
        end else if (r_cur_val > c_CLAMP_HI) begin
            w_out_val = c_CLAMP_HI;
        end
    end
`else
    assign w_out_val = r_cur_val;
`endif

    assign bus.cmd_ready = w_cmd_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_x     = r_x0 + 16'(r_col);
    assign bus.out_y     = r_y0 + 16'(r_row);
    assign bus.out_val   = w_out_val;
    assign bus.out_last  = w_out_valid & w_col_end & w_row_end;
    assign bus.busy      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_plane_span_walker.sv
`default_nettype none
// ============================================================================
// Module      : tb_plane_span_walker
// Description : Self-checking bench for plane_span_walker: 4x2, 4x1 and 1x1
//               tile instances, expected pixels from direct plane evaluation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_plane_span_walker;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [31:0] val;
        logic        last;
    } pix_t;

    logic clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;
    pix_t exp_q[$];

    always #5 clk = ~clk;

    plane_span_walker_if if_a ();
    plane_span_walker_if if_b ();
    plane_span_walker_if if_c ();

    plane_span_walker #(.FRAC_BITS(8), .TILE_W(4), .TILE_H(2)) u_dut_a (
        .clock (clk), .reset_n (reset_n), .bus (if_a));
    plane_span_walker #(.FRAC_BITS(8), .TILE_W(4), .TILE_H(1)) u_dut_b (
        .clock (clk), .reset_n (reset_n), .bus (if_b));
    plane_span_walker #(.FRAC_BITS(8), .TILE_W(1), .TILE_H(1)) u_dut_c (
        .clock (clk), .reset_n (reset_n), .bus (if_c));

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] clamp_model(input logic [31:0] v);
`ifdef INTERP_CLAMP_EN
        if (v[31]) return 32'd0;
        if (v > 32'h0000_FFFF) return 32'h0000_FFFF;
`endif
        return v;
    endfunction

    // Direct evaluation x*ddx + y*ddy + c (mod 2^32) on unwrapped coordinates.
    function automatic logic [31:0] direct_val(input logic [31:0] x, input logic [31:0] y,
                                               input logic [31:0] ddx, input logic [31:0] ddy,
                                               input logic [31:0] c);
        return x * ddx + y * ddy + c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tile_a(input logic [31:0] ddx, input logic [31:0] ddy, input logic [31:0] c,
                               input logic [15:0] x0, input logic [15:0] y0);
        pix_t p;
        for (int r = 0; r < 2; r++) begin
            for (int col = 0; col < 4; col++) begin
                p.x    = x0 + 16'(col);
                p.y    = y0 + 16'(r);
                p.val  = clamp_model(direct_val(32'(x0) + 32'(col), 32'(y0) + 32'(r), ddx, ddy, c));
                p.last = (col == 3) && (r == 1);
                exp_q.push_back(p);
            end
        end
    endtask

    // One 4x2 tile on instance A. mode 0: ready always, 1: ready 1,0,0 repeating, 2: random.
    task automatic run_tile_a(input logic [31:0] ddx, input logic [31:0] ddy, input logic [31:0] c,
                              input logic [15:0] x0, input logic [15:0] y0, input int mode);
        int   guard;
        int   lat;
        int   cyc;
        int   seq;
        logic stall;
        logic rdy;
        pix_t cur;
        pix_t held;
        pix_t exp;
        push_tile_a(ddx, ddy, c, x0, y0);
        if_a.cmd_ddx = ddx; if_a.cmd_ddy = ddy; if_a.cmd_c = c;
        if_a.cmd_x0 = x0;   if_a.cmd_y0 = y0;   if_a.cmd_valid = 1'b1;
        guard = 0;
        while (!if_a.cmd_ready && guard < 20) begin
            step();
            guard++;
        end
        // Command is presented after edge P; first pixel must follow edge P+3.
        lat = 0;
        do begin
            step();
            lat++;
            if (lat == 1) begin
                if_a.cmd_valid = 1'b0;
                if_a.cmd_ddx = $urandom; if_a.cmd_ddy = $urandom; if_a.cmd_c = $urandom;
                if_a.cmd_x0 = 16'($urandom); if_a.cmd_y0 = 16'($urandom);
            end
        end while (!if_a.out_valid && lat < 10);
        total++;
        if (lat != 3) begin
            bad++;
            $display("FAIL latency: got %0d edges want 3", lat);
        end
        stall = 1'b0;
        seq   = 0;
        cyc   = 0;
        while (exp_q.size() > 0 && cyc < 200) begin
            cur = '{if_a.out_x, if_a.out_y, if_a.out_val, if_a.out_last};
            if (stall) begin
                total++;
                if (!if_a.out_valid || cur !== held) begin
                    bad++;
                    $display("FAIL stall_hold: got v=%b %h want v=1 %h", if_a.out_valid, cur, held);
                end
            end
            if (if_a.out_valid) begin
                case (mode)
                    0:       rdy = 1'b1;
                    1:       rdy = (seq % 3 == 0);
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                seq++;
                if_a.out_ready = rdy;
                if (rdy) begin
                    exp = exp_q.pop_front();
                    total++;
                    if (cur !== exp) begin
                        bad++;
                        $display("FAIL pixel: got x=%h y=%h val=%h last=%b want x=%h y=%h val=%h last=%b",
                                 cur.x, cur.y, cur.val, cur.last, exp.x, exp.y, exp.val, exp.last);
                    end
                end
                held  = cur;
                stall = !rdy;
            end else begin
                stall = 1'b0;
            end
            step();
            cyc++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL tile_timeout: got %0d pixels missing want 0", exp_q.size());
            exp_q.delete();
        end
        if_a.out_ready = 1'b1;
        total++;
        if ({if_a.out_valid, if_a.cmd_ready, if_a.busy} !== 3'b010) begin
            bad++;
            $display("FAIL tile_end: got valid/ready/busy=%b want 010",
                     {if_a.out_valid, if_a.cmd_ready, if_a.busy});
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        total++;
        if ({if_a.cmd_ready, if_a.out_valid, if_a.out_last, if_a.busy} !== 4'b1000) begin
            bad++;
            $display("FAIL reset_ctrl_a: got %b want 1000",
                     {if_a.cmd_ready, if_a.out_valid, if_a.out_last, if_a.busy});
        end
        total++;
        if ({if_a.out_x, if_a.out_y, if_a.out_val} !== 64'd0) begin
            bad++;
            $display("FAIL reset_data_a: got %h want 0", {if_a.out_x, if_a.out_y, if_a.out_val});
        end
        total++;
        if ({if_b.cmd_ready, if_b.out_valid, if_b.busy, if_c.cmd_ready, if_c.out_valid, if_c.busy} !== 6'b100100) begin
            bad++;
            $display("FAIL reset_ctrl_bc: got %b want 100100",
                     {if_b.cmd_ready, if_b.out_valid, if_b.busy, if_c.cmd_ready, if_c.out_valid, if_c.busy});
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        run_tile_a(32'h100, 32'h200, 32'h1000, 16'd4, 16'd2, 0);
    endtask

    task automatic test_backpressure();
        run_tile_a(32'h100, 32'h200, 32'h1000, 16'd4, 16'd2, 1);
    endtask

    // 4x1 tile on instance B; vals/xs hold pixel 0 in their top slice.
    task automatic run_b(input logic [31:0] ddx, input logic [31:0] c, input logic [15:0] x0,
                         input logic [127:0] vals, input logic [63:0] xs);
        int   guard;
        int   n;
        pix_t cur;
        pix_t exp;
        if_b.cmd_ddx = ddx; if_b.cmd_ddy = 32'd0; if_b.cmd_c = c;
        if_b.cmd_x0 = x0;   if_b.cmd_y0 = 16'd5;  if_b.cmd_valid = 1'b1;
        guard = 0;
        while (!if_b.cmd_ready && guard < 20) begin
            step();
            guard++;
        end
        step();
        if_b.cmd_valid = 1'b0;
        n = 0;
        guard = 0;
        while (n < 4 && guard < 20) begin
            if (if_b.out_valid) begin
                cur = '{if_b.out_x, if_b.out_y, if_b.out_val, if_b.out_last};
                exp = '{xs[16*(3-n) +: 16], 16'd5, clamp_model(vals[32*(3-n) +: 32]), (n == 3)};
                total++;
                if (cur !== exp) begin
                    bad++;
                    $display("FAIL span_b[%0d]: got x=%h val=%h last=%b want x=%h val=%h last=%b",
                             n, cur.x, cur.val, cur.last, exp.x, exp.val, exp.last);
                end
                n++;
            end
            step();
            guard++;
        end
        if (n < 4) begin
            total++;
            bad++;
            $display("FAIL span_b_timeout: got %0d pixels want 4", n);
        end
    endtask

    task automatic test_negative_wrap();
        run_b(32'hFFFF_FF80, 32'd0, 16'd0,
              {32'h0000_0000, 32'hFFFF_FF80, 32'hFFFF_FF00, 32'hFFFF_FE80},
              {16'd0, 16'd1, 16'd2, 16'd3});
        run_b(32'h100, 32'd0, 16'hFFFF,
              {32'h00FF_FF00, 32'h0100_0000, 32'h0100_0100, 32'h0100_0200},
              {16'hFFFF, 16'h0000, 16'h0001, 16'h0002});
    endtask

    task automatic test_one_by_one();
        int guard;
        int n;
        if_c.cmd_ddx = 32'd1; if_c.cmd_ddy = 32'd2; if_c.cmd_c = 32'h1234;
        if_c.cmd_x0 = 16'd7;  if_c.cmd_y0 = 16'd9;  if_c.cmd_valid = 1'b1;
        step();
        if_c.cmd_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (if_c.out_valid) begin
                n++;
                total++;
                if ({if_c.out_x, if_c.out_y, if_c.out_val, if_c.out_last} !==
                    {16'd7, 16'd9, 32'h0000_124D, 1'b1}) begin
                    bad++;
                    $display("FAIL one_pixel: got x=%h y=%h val=%h last=%b want x=0007 y=0009 val=0000124d last=1",
                             if_c.out_x, if_c.out_y, if_c.out_val, if_c.out_last);
                end
            end
            step();
        end
        total++;
        if (n != 1) begin
            bad++;
            $display("FAIL one_count: got %0d pixels want 1", n);
        end
        guard = 0;
        total++;
        if ({if_c.cmd_ready, if_c.busy} !== 2'b10) begin
            bad++;
            $display("FAIL one_idle: got ready/busy=%b want 10", {if_c.cmd_ready, if_c.busy});
        end
    endtask

    task automatic test_clamp();
        run_tile_a(32'd0, 32'd0, 32'hFFFF_FF00, 16'd0, 16'd0, 0);
        run_tile_a(32'd0, 32'd0, 32'h0002_0000, 16'd0, 16'd0, 0);
    endtask

    // Second command held valid while the first tile walks; it must wait for IDLE.
    task automatic test_back_to_back();
        int   cyc;
        int   accepted;
        int   gap;
        logic hs_cmd;
        logic last_seen;
        logic gap_done;
        pix_t cur;
        pix_t exp;
        push_tile_a(32'd1, 32'd2, 32'd3, 16'd0, 16'd0);
        push_tile_a(32'h10, 32'h20, 32'h30, 16'd100, 16'd200);
        if_a.cmd_ddx = 32'd1; if_a.cmd_ddy = 32'd2; if_a.cmd_c = 32'd3;
        if_a.cmd_x0 = 16'd0;  if_a.cmd_y0 = 16'd0;  if_a.cmd_valid = 1'b1;
        if_a.out_ready = 1'b1;
        accepted  = 0;
        gap       = 0;
        last_seen = 1'b0;
        gap_done  = 1'b0;
        cyc       = 0;
        while (exp_q.size() > 0 && cyc < 100) begin
            hs_cmd = if_a.cmd_valid && if_a.cmd_ready;
            if (if_a.out_valid) begin
                if (last_seen && !gap_done) begin
                    gap_done = 1'b1;
                    total++;
                    if (gap != 3) begin
                        bad++;
                        $display("FAIL b2b_gap: got %0d idle cycles want 3", gap);
                    end
                end
                cur = '{if_a.out_x, if_a.out_y, if_a.out_val, if_a.out_last};
                exp = exp_q.pop_front();
                total++;
                if (cur !== exp) begin
                    bad++;
                    $display("FAIL b2b_pixel: got x=%h y=%h val=%h last=%b want x=%h y=%h val=%h last=%b",
                             cur.x, cur.y, cur.val, cur.last, exp.x, exp.y, exp.val, exp.last);
                end
                if (cur.last) last_seen = 1'b1;
            end else if (last_seen && !gap_done) begin
                gap++;
            end
            step();
            cyc++;
            if (hs_cmd) begin
                accepted++;
                if (accepted == 1) begin
                    if_a.cmd_ddx = 32'h10; if_a.cmd_ddy = 32'h20; if_a.cmd_c = 32'h30;
                    if_a.cmd_x0 = 16'd100; if_a.cmd_y0 = 16'd200;
                end else begin
                    if_a.cmd_valid = 1'b0;
                end
            end
        end
        if_a.cmd_valid = 1'b0;
        if (exp_q.size() != 0 || !gap_done) begin
            total++;
            bad++;
            $display("FAIL b2b_timeout: got %0d pixels missing gap_seen=%b want 0 and 1", exp_q.size(), gap_done);
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        if_a.cmd_ddx = 32'h100; if_a.cmd_ddy = 32'h200; if_a.cmd_c = 32'h1000;
        if_a.cmd_x0 = 16'd4;    if_a.cmd_y0 = 16'd2;    if_a.cmd_valid = 1'b1;
        if_a.out_ready = 1'b1;
        step();
        if_a.cmd_valid = 1'b0;
        guard = 0;
        while (!if_a.out_valid && guard < 10) begin
            step();
            guard++;
        end
        step();
        step();
        reset_n = 1'b0;
        step();
        total++;
        if ({if_a.out_valid, if_a.cmd_ready, if_a.busy, if_a.out_last} !== 4'b0100) begin
            bad++;
            $display("FAIL mid_reset: got valid/ready/busy/last=%b want 0100",
                     {if_a.out_valid, if_a.cmd_ready, if_a.busy, if_a.out_last});
        end
        reset_n = 1'b1;
        run_tile_a(32'h100, 32'h200, 32'h1000, 16'd4, 16'd2, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 1000; i++) begin
            run_tile_a($urandom, $urandom, $urandom, 16'($urandom), 16'($urandom), 2);
        end
    endtask

    initial begin
        reset_n = 1'b1;
        if_a.cmd_valid = 1'b0; if_a.cmd_ddx = '0; if_a.cmd_ddy = '0; if_a.cmd_c = '0;
        if_a.cmd_x0 = '0; if_a.cmd_y0 = '0; if_a.out_ready = 1'b1;
        if_b.cmd_valid = 1'b0; if_b.cmd_ddx = '0; if_b.cmd_ddy = '0; if_b.cmd_c = '0;
        if_b.cmd_x0 = '0; if_b.cmd_y0 = '0; if_b.out_ready = 1'b1;
        if_c.cmd_valid = 1'b0; if_c.cmd_ddx = '0; if_c.cmd_ddy = '0; if_c.cmd_c = '0;
        if_c.cmd_x0 = '0; if_c.cmd_y0 = '0; if_c.out_ready = 1'b1;
        #1;
        test_reset();
        test_basic();
        test_backpressure();
        test_negative_wrap();
        test_one_by_one();
        test_clamp();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
